fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter: N requesters share one FIFO write port, up to MAX_BURST beats per grant.
// Beats are zero-latency (gnt/fifo_wr_en combinational); fifo_full stalls the burst in place without losing ownership.
module fifo_write_arbiter #(
   parameter int W         = 8,
   parameter int N         = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       din,
   output logic [N-1:0]         gnt,
   input  logic                 fifo_full,
   output logic                 fifo_wr_en,
   output logic [W-1:0]         fifo_din,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy
);

   localparam int OW = $clog2(N);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

   logic [W-1:0]    din_w [N];
   logic [OW-1:0]   owner_nxt;
   logic [OW-1:0]   pick;
   logic [OW-1:0]   cand;
   logic            pick_vld;
   logic            own_req;
   logic            beat;
   logic            last_beat;
   int              cand_i;

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign din_w[g] = din[g*W +: W];
   end

   assign own_req   = req[owner_q];
   assign beat      = (state_q == BURST) && own_req && !fifo_full;
   assign last_beat = beat && (beat_cnt_q == CW'(MAX_BURST - 1));
   assign owner_nxt = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

   // Scan rr_ptr, rr_ptr+1, ... with wrap; first set request wins.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      cand_i   = 0;
      cand     = '0;
      for (int i = 0; i < N; i++) begin
         cand_i = int'(rr_ptr_q) + i;
         if (cand_i >= N) begin
            cand_i = cand_i - N;
         end
         cand = OW'(cand_i);
         if (!pick_vld && req[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (!fifo_full && pick_vld) begin
               owner_d    = pick;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + CW'(1);
            end
            // A dropped request or a full burst both hand priority to the next index.
            if (!own_req || last_beat) begin
               state_d  = IDLE;
               rr_ptr_d = owner_nxt;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      gnt        = '0;
      fifo_wr_en = 1'b0;
      busy       = (state_q == BURST);
      if (beat) begin
         gnt[owner_q] = 1'b1;
         fifo_wr_en   = 1'b1;
      end
   end

   assign fifo_din = din_w[owner_q];
   assign owner    = owner_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-cycle vector checks plus a write-data scoreboard.
module tb_fifo_write_arbiter;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int MB = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] din = '0;
   logic           fifo_full = 1'b0;
   logic [N-1:0]   gnt;
   logic           fifo_wr_en;
   logic [W-1:0]   fifo_din;
   logic [1:0]     owner;
   logic           busy;

   fifo_write_arbiter #(.W(W), .N(N), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .din        (din),
      .gnt        (gnt),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .owner      (owner),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [3:0] rq;
      logic       f;
      logic [3:0] g;
      logic       wr;
      logic       b;
      logic [1:0] o;
      string      nm;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] wd[N];
   logic [7:0] sb[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         rot_wr = 0;

   function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic f,
                               input logic [3:0] g, input logic wr, input logic b,
                               input logic [1:0] o, input string nm);
      vec_t v;
      v.r = r; v.rq = rq; v.f = f; v.g = g; v.wr = wr; v.b = b; v.o = o; v.nm = nm;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One cycle: drive at posedge+1, sample combinational outputs at posedge+4.
   task automatic step(input vec_t v);
      logic [7:0] exp_d;
      @(posedge clk);
      #1;
      rst       = v.r;
      req       = v.rq;
      fifo_full = v.f;
      for (int i = 0; i < N; i++) din[i*W +: W] = wd[i];
      if (v.wr) sb.push_back(wd[v.o]);
      #3;
      chk({v.nm, ".gnt"},   32'(gnt),        32'(v.g));
      chk({v.nm, ".wr_en"}, 32'(fifo_wr_en), 32'(v.wr));
      chk({v.nm, ".busy"},  32'(busy),       32'(v.b));
      chk({v.nm, ".owner"}, 32'(owner),      32'(v.o));
      chk({v.nm, ".din"},   32'(fifo_din),   32'(wd[v.o]));
      chk({v.nm, ".wr_while_full"}, 32'(fifo_wr_en & fifo_full), 32'(0));
      if (fifo_wr_en) begin
         if (v.nm == "rot" || v.nm == "rst_rel") rot_wr++;
         chk({v.nm, ".sb_avail"}, 32'(sb.size() > 0), 32'(1));
         if (sb.size() > 0) begin
            exp_d = sb.pop_front();
            chk({v.nm, ".sb_data"}, 32'(fifo_din), 32'(exp_d));
         end
      end
      for (int i = 0; i < N; i++) if (v.g[i]) wd[i] = wd[i] + 8'd1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) wd[i] = 8'(i * 16);
      #1 rst = 1'b0;

      // Reset, release, then five 4-beat bursts in owner order 0,1,2,3,0.
      tbl.push_back(mk(0, 4'hF, 0, 4'h0, 0, 0, 2'd0, "rst"));
      tbl.push_back(mk(0, 4'hF, 0, 4'h0, 0, 0, 2'd0, "rst"));
      tbl.push_back(mk(1, 4'hF, 0, 4'h0, 0, 0, 2'd0, "rst_rel"));
      for (int b = 0; b < 5; b++) begin
         string nm;
         nm = (b == 4) ? "rot5" : "rot";
         if (b > 0) tbl.push_back(mk(1, 4'hF, 0, 4'h0, 0, 0, 2'((b - 1) % 4), nm));
         for (int k = 0; k < MB; k++)
            tbl.push_back(mk(1, 4'hF, 0, 4'(1 << (b % 4)), 1, 1, 2'(b % 4), nm));
      end
      for (int k = 0; k < tbl.size(); k++) step(tbl[k]);
      chk("rot_throughput", 32'(rot_wr), 32'(16));

      step(mk(1, 4'h0, 0, 4'h0, 0, 0, 2'd0, "gap"));

      // Early drop by requester 2 after two words, then rr_ptr=3 picks 3 over 0.
      wd[2] = 8'hA0;
      step(mk(1, 4'h4, 0, 4'h0, 0, 0, 2'd0, "drop_idle"));
      step(mk(1, 4'h4, 0, 4'h4, 1, 1, 2'd2, "drop_b1"));
      step(mk(1, 4'h4, 0, 4'h4, 1, 1, 2'd2, "drop_b2"));
      step(mk(1, 4'h0, 0, 4'h0, 0, 1, 2'd2, "drop_exit"));
      step(mk(1, 4'h9, 0, 4'h0, 0, 0, 2'd2, "drop_rr"));
      step(mk(1, 4'h9, 0, 4'h8, 1, 1, 2'd3, "drop_own3"));
      step(mk(1, 4'h1, 0, 4'h0, 0, 1, 2'd3, "wrap_exit"));

      // Backpressure mid-burst: ownership and beat count hold through the stall.
      step(mk(1, 4'h1, 0, 4'h0, 0, 0, 2'd3, "bp_idle"));
      step(mk(1, 4'h1, 0, 4'h1, 1, 1, 2'd0, "bp_b1"));
      for (int k = 0; k < 3; k++) step(mk(1, 4'h1, 1, 4'h0, 0, 1, 2'd0, "bp_stall"));
      for (int k = 0; k < 3; k++) step(mk(1, 4'h1, 0, 4'h1, 1, 1, 2'd0, "bp_b"));
      step(mk(1, 4'h0, 0, 4'h0, 0, 0, 2'd0, "bp_done"));

      // Reset during owner 1's burst; arbitration restarts from index 0.
      step(mk(1, 4'h2, 0, 4'h0, 0, 0, 2'd0, "mr_idle"));
      step(mk(1, 4'h2, 0, 4'h2, 1, 1, 2'd1, "mr_b1"));
      step(mk(1, 4'h2, 0, 4'h2, 1, 1, 2'd1, "mr_b2"));
      step(mk(0, 4'h2, 0, 4'h0, 0, 0, 2'd0, "mr_rst"));
      step(mk(1, 4'h3, 0, 4'h0, 0, 0, 2'd0, "mr_rel"));
      step(mk(1, 4'h3, 0, 4'h1, 1, 1, 2'd0, "mr_own0"));
      step(mk(1, 4'h0, 0, 4'h0, 0, 1, 2'd0, "mr_exit"));

      // FIFO full while idle blocks arbitration until it clears.
      step(mk(1, 4'h4, 1, 4'h0, 0, 0, 2'd0, "fi_full"));
      step(mk(1, 4'h4, 1, 4'h0, 0, 0, 2'd0, "fi_full"));
      step(mk(1, 4'h4, 0, 4'h0, 0, 0, 2'd0, "fi_rel"));
      step(mk(1, 4'h4, 0, 4'h4, 1, 1, 2'd2, "fi_own2"));
      step(mk(1, 4'h0, 0, 4'h0, 0, 1, 2'd2, "fi_exit"));

      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
